commit_trace_queue: RTL and testbench

COMMIT_TRACE_QUEUE -- requirements
Module: commit_trace_queue

---
 rtl/commit_trace_queue_if.sv | 80 ++++++++
 rtl/commit_trace_queue.sv | 181 ++++++++++++++++++
 tb/tb_commit_trace_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_queue_if.sv
// Commit-trace bus: retired-instruction/writeback/trap capture side plus the checker-side drain.
// The producer uses the master modport; the trace queue uses the slave modport.
interface commit_trace_queue_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_commit_valid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_insn;
    logic            in_int0_valid;
    logic [4:0]      in_int0_addr;
    logic [XLEN-1:0] in_int0_data;
    logic            in_int1_valid;
    logic [4:0]      in_int1_addr;
    logic [XLEN-1:0] in_int1_data;
    logic            in_fp0_valid;
    logic [4:0]      in_fp0_addr;
    logic [XLEN-1:0] in_fp0_data;
    logic            in_fp1_valid;
    logic [4:0]      in_fp1_addr;
    logic [XLEN-1:0] in_fp1_data;
    logic            in_trap_valid;
    logic [XLEN-1:0] in_trap_cause;
    logic            clear;

    logic            out_valid;
    logic            out_ready;
    logic            out_commit_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_insn;
    logic            out_int0_valid;
    logic [4:0]      out_int0_addr;
    logic [XLEN-1:0] out_int0_data;
    logic            out_int1_valid;
    logic [4:0]      out_int1_addr;
    logic [XLEN-1:0] out_int1_data;
    logic            out_fp0_valid;
    logic [4:0]      out_fp0_addr;
    logic [XLEN-1:0] out_fp0_data;
    logic            out_fp1_valid;
    logic [4:0]      out_fp1_addr;
    logic [XLEN-1:0] out_fp1_data;
    logic            out_trap_valid;
    logic [XLEN-1:0] out_trap_cause;
    logic [31:0]     out_cycle;
    logic            almost_full;
    logic            overflow;
    logic [15:0]     drop_count;

    modport master (
        output in_commit_valid, in_pc, in_insn,
        output in_int0_valid, in_int0_addr, in_int0_data,
        output in_int1_valid, in_int1_addr, in_int1_data,
        output in_fp0_valid, in_fp0_addr, in_fp0_data,
        output in_fp1_valid, in_fp1_addr, in_fp1_data,
        output in_trap_valid, in_trap_cause, clear, out_ready,
        input  out_valid, out_commit_valid, out_pc, out_insn,
        input  out_int0_valid, out_int0_addr, out_int0_data,
        input  out_int1_valid, out_int1_addr, out_int1_data,
        input  out_fp0_valid, out_fp0_addr, out_fp0_data,
        input  out_fp1_valid, out_fp1_addr, out_fp1_data,
        input  out_trap_valid, out_trap_cause, out_cycle,
        input  almost_full, overflow, drop_count
    );

    modport slave (
        input  in_commit_valid, in_pc, in_insn,
        input  in_int0_valid, in_int0_addr, in_int0_data,
        input  in_int1_valid, in_int1_addr, in_int1_data,
        input  in_fp0_valid, in_fp0_addr, in_fp0_data,
        input  in_fp1_valid, in_fp1_addr, in_fp1_data,
        input  in_trap_valid, in_trap_cause, clear, out_ready,
        output out_valid, out_commit_valid, out_pc, out_insn,
        output out_int0_valid, out_int0_addr, out_int0_data,
        output out_int1_valid, out_int1_addr, out_int1_data,
        output out_fp0_valid, out_fp0_addr, out_fp0_data,
        output out_fp1_valid, out_fp1_addr, out_fp1_data,
        output out_trap_valid, out_trap_cause, out_cycle,
        output almost_full, overflow, drop_count
    );
endinterface

// File: rtl/commit_trace_queue.sv
// Commit trace FIFO: captures one record per event cycle, drains through a valid/ready port.
// Define COMMIT_TRACE_TIMESTAMP_EN to stamp each record with a free-running capture-cycle count.
module commit_trace_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 64
) (
    input  logic clock,
    input  logic reset,
    commit_trace_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic            commit_valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            int0_valid;
        logic [4:0]      int0_addr;
        logic [XLEN-1:0] int0_data;
        logic            int1_valid;
        logic [4:0]      int1_addr;
        logic [XLEN-1:0] int1_data;
        logic            fp0_valid;
        logic [4:0]      fp0_addr;
        logic [XLEN-1:0] fp0_data;
        logic            fp1_valid;
        logic [4:0]      fp1_addr;
        logic [XLEN-1:0] fp1_data;
        logic            trap_valid;
        logic [XLEN-1:0] trap_cause;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_count_q, drop_count_d;

    rec_t rec_in;
    rec_t head;
    logic event_c, empty, full, pop, push, drop;

    // Payload of any slot not marked valid is stored as zero.
    always_comb begin
        rec_in              = '0;
        rec_in.commit_valid = bus.in_commit_valid;
        rec_in.pc           = bus.in_commit_valid ? bus.in_pc   : '0;
        rec_in.insn         = bus.in_commit_valid ? bus.in_insn : '0;
        rec_in.int0_valid   = bus.in_int0_valid;
        rec_in.int0_addr    = bus.in_int0_valid ? bus.in_int0_addr : '0;
        rec_in.int0_data    = bus.in_int0_valid ? bus.in_int0_data : '0;
        rec_in.int1_valid   = bus.in_int1_valid;
        rec_in.int1_addr    = bus.in_int1_valid ? bus.in_int1_addr : '0;
        rec_in.int1_data    = bus.in_int1_valid ? bus.in_int1_data : '0;
        rec_in.fp0_valid    = bus.in_fp0_valid;
        rec_in.fp0_addr     = bus.in_fp0_valid ? bus.in_fp0_addr : '0;
        rec_in.fp0_data     = bus.in_fp0_valid ? bus.in_fp0_data : '0;
        rec_in.fp1_valid    = bus.in_fp1_valid;
        rec_in.fp1_addr     = bus.in_fp1_valid ? bus.in_fp1_addr : '0;
        rec_in.fp1_data     = bus.in_fp1_valid ? bus.in_fp1_data : '0;
        rec_in.trap_valid   = bus.in_trap_valid;
        rec_in.trap_cause   = bus.in_trap_valid ? bus.in_trap_cause : '0;
    end

    assign event_c = bus.in_commit_valid | bus.in_int0_valid | bus.in_int1_valid |
                     bus.in_fp0_valid | bus.in_fp1_valid | bus.in_trap_valid;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = !empty && bus.out_ready;
    assign push    = event_c && (!full || pop);
    assign drop    = event_c && full && !pop;

    // Next-state: pointers, occupancy, storage and drop accounting (clear beats a drop).
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rec_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (bus.clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Record storage needs no reset; it is only visible through a nonzero occupancy.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] stamp_q [DEPTH];
    logic [31:0] stamp_d [DEPTH];

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        stamp_d = stamp_q;
        if (push) begin
            stamp_d[wr_ptr_q] = cycle_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    always_ff @(posedge clock) begin
        stamp_q <= stamp_d;
    end

    assign bus.out_cycle = empty ? 32'd0 : stamp_q[rd_ptr_q];
`else
    assign bus.out_cycle = 32'd0;
`endif

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign bus.out_valid        = !empty;
    assign bus.out_commit_valid = head.commit_valid;
    assign bus.out_pc           = head.pc;
    assign bus.out_insn         = head.insn;
    assign bus.out_int0_valid   = head.int0_valid;
    assign bus.out_int0_addr    = head.int0_addr;
    assign bus.out_int0_data    = head.int0_data;
    assign bus.out_int1_valid   = head.int1_valid;
    assign bus.out_int1_addr    = head.int1_addr;
    assign bus.out_int1_data    = head.int1_data;
    assign bus.out_fp0_valid    = head.fp0_valid;
    assign bus.out_fp0_addr     = head.fp0_addr;
    assign bus.out_fp0_data     = head.fp0_data;
    assign bus.out_fp1_valid    = head.fp1_valid;
    assign bus.out_fp1_addr     = head.fp1_addr;
    assign bus.out_fp1_data     = head.fp1_data;
    assign bus.out_trap_valid   = head.trap_valid;
    assign bus.out_trap_cause   = head.trap_cause;
    assign bus.almost_full      = (count_q >= CW'(DEPTH - 2));
    assign bus.overflow         = overflow_q;
    assign bus.drop_count       = drop_count_q;
endmodule

// File: tb/tb_commit_trace_queue.sv
// Testbench for commit_trace_queue: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_commit_trace_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    commit_trace_queue_if #(.XLEN(XLEN)) bus ();

    commit_trace_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        cv;
        logic [63:0] pc;
        logic [31:0] insn;
        logic        i0v;
        logic [4:0]  i0a;
        logic [63:0] i0d;
        logic        i1v;
        logic [4:0]  i1a;
        logic [63:0] i1d;
        logic        f0v;
        logic [4:0]  f0a;
        logic [63:0] f0d;
        logic        f1v;
        logic [4:0]  f1a;
        logic [63:0] f1d;
        logic        tv;
        logic [63:0] tc;
        logic [31:0] cyc;
    } rec_t;

    rec_t        mq[$];
    bit          m_ovf = 1'b0;
    int          m_dc  = 0;
    int unsigned m_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rec_t capture();
        rec_t r;
        r.cv   = bus.in_commit_valid;
        r.pc   = bus.in_commit_valid ? bus.in_pc   : 64'd0;
        r.insn = bus.in_commit_valid ? bus.in_insn : 32'd0;
        r.i0v  = bus.in_int0_valid;
        r.i0a  = bus.in_int0_valid ? bus.in_int0_addr : 5'd0;
        r.i0d  = bus.in_int0_valid ? bus.in_int0_data : 64'd0;
        r.i1v  = bus.in_int1_valid;
        r.i1a  = bus.in_int1_valid ? bus.in_int1_addr : 5'd0;
        r.i1d  = bus.in_int1_valid ? bus.in_int1_data : 64'd0;
        r.f0v  = bus.in_fp0_valid;
        r.f0a  = bus.in_fp0_valid ? bus.in_fp0_addr : 5'd0;
        r.f0d  = bus.in_fp0_valid ? bus.in_fp0_data : 64'd0;
        r.f1v  = bus.in_fp1_valid;
        r.f1a  = bus.in_fp1_valid ? bus.in_fp1_addr : 5'd0;
        r.f1d  = bus.in_fp1_valid ? bus.in_fp1_data : 64'd0;
        r.tv   = bus.in_trap_valid;
        r.tc   = bus.in_trap_valid ? bus.in_trap_cause : 64'd0;
        r.cyc  = m_cyc;
        return r;
    endfunction

    // Reference model: advance by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit   ev, full, pop, drop;
        rec_t r;
        if (rst_n) begin
            ev   = bus.in_commit_valid | bus.in_int0_valid | bus.in_int1_valid |
                   bus.in_fp0_valid | bus.in_fp1_valid | bus.in_trap_valid;
            full = (mq.size() == DEPTH);
            pop  = (mq.size() > 0) && bus.out_ready;
            drop = ev && full && !pop;
            r    = capture();
            if (pop) void'(mq.pop_front());
            if (ev && (!full || pop)) mq.push_back(r);
            if (bus.clear) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_dc < 65535) m_dc++;
            end
            m_cyc++;
        end
    endtask

    task automatic check_all(input string ph);
        rec_t e;
        bit   v;
        v = (mq.size() > 0);
        if (v) e = mq[0];
        else   e = '{default: '0};
        chk({ph, ".out_valid"},   64'(bus.out_valid),        64'(v));
        chk({ph, ".commit_v"},    64'(bus.out_commit_valid), 64'(e.cv));
        chk({ph, ".pc"},          bus.out_pc,                e.pc);
        chk({ph, ".insn"},        64'(bus.out_insn),         64'(e.insn));
        chk({ph, ".int0"},        {57'(bus.out_int0_valid), bus.out_int0_addr, 2'b00},
                                  {57'(e.i0v), e.i0a, 2'b00});
        chk({ph, ".int0_data"},   bus.out_int0_data,         e.i0d);
        chk({ph, ".int1"},        {57'(bus.out_int1_valid), bus.out_int1_addr, 2'b00},
                                  {57'(e.i1v), e.i1a, 2'b00});
        chk({ph, ".int1_data"},   bus.out_int1_data,         e.i1d);
        chk({ph, ".fp0"},         {57'(bus.out_fp0_valid), bus.out_fp0_addr, 2'b00},
                                  {57'(e.f0v), e.f0a, 2'b00});
        chk({ph, ".fp0_data"},    bus.out_fp0_data,          e.f0d);
        chk({ph, ".fp1"},         {57'(bus.out_fp1_valid), bus.out_fp1_addr, 2'b00},
                                  {57'(e.f1v), e.f1a, 2'b00});
        chk({ph, ".fp1_data"},    bus.out_fp1_data,          e.f1d);
        chk({ph, ".trap_v"},      64'(bus.out_trap_valid),   64'(e.tv));
        chk({ph, ".trap_cause"},  bus.out_trap_cause,        e.tc);
        chk({ph, ".almost_full"}, 64'(bus.almost_full),      64'(mq.size() >= DEPTH - 2));
        chk({ph, ".overflow"},    64'(bus.overflow),         64'(m_ovf));
        chk({ph, ".drop_count"},  64'(bus.drop_count),       64'(m_dc));
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        chk({ph, ".out_cycle"},   64'(bus.out_cycle),        64'(v ? e.cyc : 32'd0));
`else
        chk({ph, ".out_cycle"},   64'(bus.out_cycle),        64'd0);
`endif
    endtask

    task automatic tick(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    // Non-event cycle with garbage payloads under deasserted valids.
    task automatic set_idle();
        bus.in_commit_valid = 1'b0;
        bus.in_pc           = {$urandom, $urandom};
        bus.in_insn         = $urandom;
        bus.in_int0_valid   = 1'b0;
        bus.in_int0_addr    = 5'($urandom);
        bus.in_int0_data    = {$urandom, $urandom};
        bus.in_int1_valid   = 1'b0;
        bus.in_int1_addr    = 5'($urandom);
        bus.in_int1_data    = {$urandom, $urandom};
        bus.in_fp0_valid    = 1'b0;
        bus.in_fp0_addr     = 5'($urandom);
        bus.in_fp0_data     = {$urandom, $urandom};
        bus.in_fp1_valid    = 1'b0;
        bus.in_fp1_addr     = 5'($urandom);
        bus.in_fp1_data     = {$urandom, $urandom};
        bus.in_trap_valid   = 1'b0;
        bus.in_trap_cause   = {$urandom, $urandom};
    endtask

    task automatic set_event();
        logic [5:0] vm;
        set_idle();
        vm = 6'($urandom_range(1, 63));
        bus.in_commit_valid = vm[0];
        bus.in_int0_valid   = vm[1];
        bus.in_int1_valid   = vm[2];
        bus.in_fp0_valid    = vm[3];
        bus.in_fp1_valid    = vm[4];
        bus.in_trap_valid   = vm[5];
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
        m_cyc = 0;
    endtask

    initial begin
        set_idle();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_all("reset_hold");
        set_event();
        tick("reset_edge");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_step();
        check_all("post_reset");

        // Single commit + int0 writeback appears next cycle, then drains.
        set_idle();
        bus.in_commit_valid = 1'b1;
        bus.in_pc           = 64'h0000_0000_8000_0000;
        bus.in_insn         = 32'h0000_0013;
        bus.in_int0_valid   = 1'b1;
        bus.in_int0_addr    = 5'd5;
        bus.in_int0_data    = 64'h1234;
        bus.out_ready       = 1'b1;
        tick("basic");
        chk("basic.valid", 64'(bus.out_valid), 64'd1);
        chk("basic.pc", bus.out_pc, 64'h8000_0000);
        chk("basic.data", bus.out_int0_data, 64'h1234);
        set_idle();
        tick("basic_drain");
        chk("basic_drain.valid", 64'(bus.out_valid), 64'd0);

        // Ten events with a stalled checker: eight stored, two dropped.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            set_event();
            tick($sformatf("fill%0d", i));
            if (i == 5) chk("fill5.almost_full", 64'(bus.almost_full), 64'd0);
            if (i == 6) chk("fill6.almost_full", 64'(bus.almost_full), 64'd1);
        end
        chk("fill.overflow", 64'(bus.overflow), 64'd1);
        chk("fill.drop_count", 64'(bus.drop_count), 64'd2);

        // Full queue with simultaneous pop accepts the new record.
        set_event();
        bus.out_ready = 1'b1;
        tick("full_pushpop");
        chk("full_pushpop.drop_count", 64'(bus.drop_count), 64'd2);
        chk("full_pushpop.almost_full", 64'(bus.almost_full), 64'd1);

        // Clear wins over a same-cycle drop.
        bus.out_ready = 1'b0;
        set_event();
        bus.clear = 1'b1;
        tick("clear_drop");
        chk("clear_drop.overflow", 64'(bus.overflow), 64'd0);
        chk("clear_drop.drop_count", 64'(bus.drop_count), 64'd0);
        bus.clear = 1'b0;
        set_event();
        tick("drop_after_clear");
        chk("drop_after_clear.drop_count", 64'(bus.drop_count), 64'd1);

        // Drain, checking order against the model.
        set_idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick("drain");

        // All writeback slots and a trap in one cycle form a single record.
        set_idle();
        bus.in_int0_valid = 1'b1;
        bus.in_int1_valid = 1'b1;
        bus.in_fp0_valid  = 1'b1;
        bus.in_fp1_valid  = 1'b1;
        bus.in_trap_valid = 1'b1;
        bus.in_trap_cause = 64'h8000_0000_0000_0007;
        tick("all_slots");
        chk("all_slots.trap_cause", bus.out_trap_cause, 64'h8000_0000_0000_0007);
        chk("all_slots.fp1_valid", 64'(bus.out_fp1_valid), 64'd1);
        set_idle();
        tick("all_slots_drain");
        chk("all_slots_drain.valid", 64'(bus.out_valid), 64'd0);

        // Reset with three entries queued discards them immediately.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_event();
            tick("pre_reset");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_reset.valid", 64'(bus.out_valid), 64'd0);
        check_all("mid_reset");
        tick("in_reset");
        #2 rst_n = 1'b1;
        set_event();
        tick("first_after_reset");
        chk("first_after_reset.valid", 64'(bus.out_valid), 64'd1);
        chk("first_after_reset.cycle", 64'(bus.out_cycle), 64'd0);
        set_idle();
        tick("second_after_reset");

        // Randomized traffic with varying drain pressure and occasional clear.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 6) set_event();
            else                          set_idle();
            if ((i / 50) % 2 == 0) bus.out_ready = ($urandom_range(0, 3) == 0);
            else                   bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.clear = ($urandom_range(0, 39) == 0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
